// File: rtl/ren_conv_wb_master.sv
// Wishbone classic-cycle initiator: one bus cycle per 32-bit word of a command burst,
// write data from a valid/ready stream, read data returned on another, per-word ack timeout.
module ren_conv_wb_master #(
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [31:0]          wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [31:0]          rd_data,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        BUS   = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_r;
    logic [LEN_WIDTH-1:0] remain_r;
    logic [TO_WIDTH-1:0]  to_cnt_r;
    logic                 write_cmd_r;

    assign cmd_ready = (state_r == IDLE);
    assign wr_ready  = (state_r == WDATA);

    // Command sequencer with all bus and status outputs registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            remain_r    <= '0;
            to_cnt_r    <= '0;
            write_cmd_r <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0000_0000;
            wbm_dat_o   <= 32'h0000_0000;
            rd_valid    <= 1'b0;
            rd_data     <= 32'h0000_0000;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_adr_o   <= cmd_adr;
                        write_cmd_r <= cmd_we;
                        remain_r    <= cmd_len;
                        busy_o      <= 1'b1;
                        err_o       <= 1'b0;
                        if (cmd_len == '0) begin
                            state_r <= DONE;
                            done_o  <= 1'b1;
                        end else if (cmd_we) begin
                            state_r <= WDATA;
                        end else begin
                            state_r   <= BUS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= 4'hF;
                            to_cnt_r  <= '0;
                        end
                    end
                end
                WDATA: begin
                    if (wr_valid) begin
                        wbm_dat_o <= wr_data;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        to_cnt_r  <= '0;
                        state_r   <= BUS;
                    end
                end
                BUS: begin
                    // An ack in the final timeout cycle still completes the word.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_adr_o <= wbm_adr_o + 32'd4;
                        remain_r  <= remain_r - LEN_WIDTH'(1);
                        if (!write_cmd_r) begin
                            rd_data  <= wbm_dat_i;
                            rd_valid <= 1'b1;
                            state_r  <= RESP;
                        end else if (remain_r == LEN_WIDTH'(1)) begin
                            state_r <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_r <= WDATA;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        err_o     <= 1'b1;
                        remain_r  <= '0;
                        state_r   <= DONE;
                        done_o    <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (remain_r == '0) begin
                            state_r <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_r   <= BUS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            to_cnt_r  <= '0;
                        end
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= 4'h0;
                    rd_valid  <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
